// File: rtl/avr_pkg.sv
// Shared definitions for the AVR instruction fetch path:
// PC width default, fetch FSM states and two-word opcode patterns.
package avr_pkg;

    localparam int PC_W_DEF = 16;

    localparam logic [15:0] LDS_STS_MASK  = 16'hFC0F;
    localparam logic [15:0] LDS_STS_VAL   = 16'h9000;
    localparam logic [15:0] JMP_CALL_MASK = 16'hFE0C;
    localparam logic [15:0] JMP_CALL_VAL  = 16'h940C;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH1,
        S_FETCH2,
        S_HOLD,
        S_SKIP1,
        S_SKIP2,
        S_DISCARD
    } fetch_state_t;

endpackage

// File: rtl/avr_twoword_dec.sv
// Flags AVR opcodes that carry a second 16-bit word (LDS/STS, JMP/CALL).
// Shared with the CPU decode stage.
module avr_twoword_dec
    import avr_pkg::*;
(
    input  logic [15:0] op,
    output logic        is_two_word
);

    logic lds_sts;
    logic jmp_call;

    assign lds_sts     = (op & LDS_STS_MASK) == LDS_STS_VAL;
    assign jmp_call    = (op & JMP_CALL_MASK) == JMP_CALL_VAL;
    assign is_two_word = lds_sts | jmp_call;

endmodule

// File: rtl/avr_fetch_ctrl.sv
// AVR fetch controller: reads one or two opcode words, presents them
// to the CPU, and handles skips and branch redirects without prefetch.
module avr_fetch_ctrl
    import avr_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
) (
    input  logic            CLK,
    input  logic            RST,
    output logic [PC_W-1:0] p_addr,
    output logic            p_req,
    input  logic            p_ack,
    input  logic [15:0]     p_data,
    output logic [15:0]     instr,
    output logic [15:0]     instr_ext,
    output logic [PC_W-1:0] instr_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            br_take,
    input  logic [PC_W-1:0] br_target,
    input  logic            skip
);

    fetch_state_t    state;
    logic [PC_W-1:0] br_tgt;
    logic [PC_W-1:0] pc_inc;
    logic            two_word;

    // p_addr always points at the word being (or about to be) read,
    // so a single incrementer covers every sequential step.
    assign pc_inc = p_addr + PC_W'(1);

    avr_twoword_dec u_dec (
        .op          (p_data),
        .is_two_word (two_word)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= S_IDLE;
            p_req       <= 1'b0;
            p_addr      <= '0;
            br_tgt      <= '0;
            instr       <= '0;
            instr_ext   <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else if (br_take) begin
            instr_valid <= 1'b0;
            // An outstanding read must complete at its old address.
            if (p_req && !p_ack) begin
                state  <= S_DISCARD;
                br_tgt <= br_target;
            end else begin
                state  <= S_FETCH1;
                p_req  <= 1'b1;
                p_addr <= br_target;
            end
        end else begin
            unique case (state)
                S_IDLE: begin
                    state  <= S_FETCH1;
                    p_req  <= 1'b1;
                    p_addr <= '0;
                end
                S_FETCH1: begin
                    if (p_ack) begin
                        instr     <= p_data;
                        instr_ext <= '0;
                        instr_pc  <= p_addr;
                        p_addr    <= pc_inc;
                        if (two_word) begin
                            state <= S_FETCH2;
                        end else begin
                            state       <= S_HOLD;
                            p_req       <= 1'b0;
                            instr_valid <= 1'b1;
                        end
                    end
                end
                S_FETCH2: begin
                    if (p_ack) begin
                        instr_ext   <= p_data;
                        p_addr      <= pc_inc;
                        state       <= S_HOLD;
                        p_req       <= 1'b0;
                        instr_valid <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        p_req       <= 1'b1;
                        state       <= skip ? S_SKIP1 : S_FETCH1;
                    end
                end
                S_SKIP1: begin
                    if (p_ack) begin
                        p_addr <= pc_inc;
                        state  <= two_word ? S_SKIP2 : S_FETCH1;
                    end
                end
                // The skipped opcode's second word is read and dropped.
                S_SKIP2: begin
                    if (p_ack) begin
                        p_addr <= pc_inc;
                        state  <= S_FETCH1;
                    end
                end
                S_DISCARD: begin
                    if (p_ack) begin
                        p_addr <= br_tgt;
                        state  <= S_FETCH1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    p_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avr_fetch_ctrl.sv
// Directed bench for avr_fetch_ctrl with a small program-memory
// responder whose ack latency is adjustable per step.
module tb_avr_fetch_ctrl;

    localparam int PC_W = 16;

    logic            CLK = 1'b0;
    logic            RST = 1'b0;
    logic [PC_W-1:0] p_addr;
    logic            p_req;
    logic            p_ack = 1'b0;
    logic [15:0]     p_data = '0;
    logic [15:0]     instr;
    logic [15:0]     instr_ext;
    logic [PC_W-1:0] instr_pc;
    logic            instr_valid;
    logic            instr_ready = 1'b0;
    logic            br_take = 1'b0;
    logic [PC_W-1:0] br_target = '0;
    logic            skip = 1'b0;

    int tests = 0;
    int fails = 0;
    int ack_lat = 0;
    int wait_cnt = 0;

    avr_fetch_ctrl #(.PC_W(PC_W)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .p_addr      (p_addr),
        .p_req       (p_req),
        .p_ack       (p_ack),
        .p_data      (p_data),
        .instr       (instr),
        .instr_ext   (instr_ext),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .br_take     (br_take),
        .br_target   (br_target),
        .skip        (skip)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] mem(input logic [15:0] a);
        case (a)
            16'h0000: return 16'h50A1;
            16'h0003: return 16'h9000;
            16'h0004: return 16'h940C;
            16'h0005: return 16'h0123;
            16'h0007: return 16'h9999;
            16'h0040: return 16'h1111;
            16'hFFFF: return 16'h2222;
            default:  return 16'h0000;
        endcase
    endfunction

    task automatic respond();
        if (p_req) begin
            if (wait_cnt == ack_lat) begin
                p_ack    = 1'b1;
                p_data   = mem(p_addr);
                wait_cnt = 0;
            end else begin
                p_ack    = 1'b0;
                p_data   = 16'hDEAD;
                wait_cnt = wait_cnt + 1;
            end
        end else begin
            p_ack    = 1'b0;
            wait_cnt = 0;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        respond();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " p_req"}, 32'(p_req), 32'h0);
        chk({tag, " p_addr"}, 32'(p_addr), 32'h0);
        chk({tag, " instr"}, 32'(instr), 32'h0);
        chk({tag, " instr_ext"}, 32'(instr_ext), 32'h0);
        chk({tag, " instr_pc"}, 32'(instr_pc), 32'h0);
        chk({tag, " valid"}, 32'(instr_valid), 32'h0);
    endtask

    initial begin
        #3;
        chk_reset("por");
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        respond();

        // first fetch from address 0
        tick();
        chk("f0 req", 32'(p_req), 32'h1);
        chk("f0 addr", 32'(p_addr), 32'h0);
        chk("f0 valid", 32'(instr_valid), 32'h0);
        tick();
        chk("h0 valid", 32'(instr_valid), 32'h1);
        chk("h0 instr", 32'(instr), 32'h50A1);
        chk("h0 ext", 32'(instr_ext), 32'h0);
        chk("h0 pc", 32'(instr_pc), 32'h0);
        chk("h0 req", 32'(p_req), 32'h0);
        tick();
        chk("h0 hold valid", 32'(instr_valid), 32'h1);
        chk("h0 hold instr", 32'(instr), 32'h50A1);
        instr_ready = 1'b1;
        tick();
        chk("f1 valid", 32'(instr_valid), 32'h0);
        chk("f1 addr", 32'(p_addr), 32'h1);
        chk("f1 req", 32'(p_req), 32'h1);
        instr_ready = 1'b0;
        tick();
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        tick();
        chk("h2 pc", 32'(instr_pc), 32'h2);

        // skip over the two-word LDS at 3..4
        instr_ready = 1'b1;
        skip = 1'b1;
        tick();
        instr_ready = 1'b0;
        skip = 1'b0;
        chk("sk1 addr", 32'(p_addr), 32'h3);
        chk("sk1 valid", 32'(instr_valid), 32'h0);
        tick();
        chk("sk2 addr", 32'(p_addr), 32'h4);
        chk("sk2 valid", 32'(instr_valid), 32'h0);
        tick();
        chk("skf addr", 32'(p_addr), 32'h5);
        chk("skf valid", 32'(instr_valid), 32'h0);
        tick();
        chk("sk pc", 32'(instr_pc), 32'h5);
        chk("sk valid", 32'(instr_valid), 32'h1);
        chk("sk instr", 32'(instr), 32'h0123);

        // redirect from HOLD to a JMP at 4
        br_take = 1'b1;
        br_target = 16'h0004;
        tick();
        br_take = 1'b0;
        chk("jb valid", 32'(instr_valid), 32'h0);
        chk("jb addr", 32'(p_addr), 32'h4);
        tick();
        chk("j2 addr", 32'(p_addr), 32'h5);
        chk("j2 valid", 32'(instr_valid), 32'h0);
        tick();
        chk("j instr", 32'(instr), 32'h940C);
        chk("j ext", 32'(instr_ext), 32'h0123);
        chk("j pc", 32'(instr_pc), 32'h4);
        chk("j valid", 32'(instr_valid), 32'h1);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("j next addr", 32'(p_addr), 32'h6);
        chk("j next valid", 32'(instr_valid), 32'h0);
        tick();

        // branch while the read at 7 is stalled, retargeted once
        ack_lat = 3;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("st addr", 32'(p_addr), 32'h7);
        br_take = 1'b1;
        br_target = 16'h0030;
        tick();
        chk("d1 addr", 32'(p_addr), 32'h7);
        chk("d1 req", 32'(p_req), 32'h1);
        chk("d1 valid", 32'(instr_valid), 32'h0);
        br_target = 16'h0040;
        tick();
        br_take = 1'b0;
        chk("d2 addr", 32'(p_addr), 32'h7);
        tick();
        chk("d3 addr", 32'(p_addr), 32'h7);
        chk("d3 ack", 32'(p_ack), 32'h1);
        ack_lat = 0;
        tick();
        chk("d tgt addr", 32'(p_addr), 32'h40);
        chk("d tgt valid", 32'(instr_valid), 32'h0);
        tick();
        chk("d tgt instr", 32'(instr), 32'h1111);
        chk("d tgt pc", 32'(instr_pc), 32'h40);

        // branch coincident with ack, then wrap from 0xFFFF
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("ba ack", 32'(p_ack), 32'h1);
        br_take = 1'b1;
        br_target = 16'hFFFF;
        tick();
        br_take = 1'b0;
        chk("ba addr", 32'(p_addr), 32'hFFFF);
        chk("ba valid", 32'(instr_valid), 32'h0);
        tick();
        chk("w instr", 32'(instr), 32'h2222);
        chk("w pc", 32'(instr_pc), 32'hFFFF);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("w addr", 32'(p_addr), 32'h0);
        chk("w req", 32'(p_req), 32'h1);
        tick();
        chk("w0 pc", 32'(instr_pc), 32'h0);

        // branch beats skip in the same transfer cycle
        instr_ready = 1'b1;
        skip = 1'b1;
        br_take = 1'b1;
        br_target = 16'h0020;
        tick();
        instr_ready = 1'b0;
        skip = 1'b0;
        br_take = 1'b0;
        chk("bs addr", 32'(p_addr), 32'h20);
        tick();
        chk("bs pc", 32'(instr_pc), 32'h20);
        chk("bs valid", 32'(instr_valid), 32'h1);

        // asynchronous reset during FETCH2
        br_take = 1'b1;
        br_target = 16'h0004;
        tick();
        br_take = 1'b0;
        tick();
        chk("rf2 addr", 32'(p_addr), 32'h5);
        #2;
        RST = 1'b0;
        #1;
        chk_reset("async");
        tick();
        chk("rst hold req", 32'(p_req), 32'h0);
        RST = 1'b1;
        tick();
        chk("rel addr", 32'(p_addr), 32'h0);
        chk("rel req", 32'(p_req), 32'h1);
        tick();
        chk("rel instr", 32'(instr), 32'h50A1);
        chk("rel valid", 32'(instr_valid), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
